// File: rtl/execute_stage.sv
// Execute stage: 32-bit ALU and branch compare, one-cycle result register,
// misprediction redirect with one-instruction squash and a saturating mispredict counter.
module execute_stage #(
    parameter int MISPRED_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     stall,
    output logic                     in_ready,
    input  logic [31:0]              data_a,
    input  logic [31:0]              data_b,
    input  logic [31:0]              rs2_value,
    input  logic [4:0]               execute_instruction,
    input  logic                     condition_branch,
    input  logic                     taken,
    input  logic [31:0]              immediate_value,
    input  logic [31:0]              pc,
    input  logic [1:0]               read_status,
    input  logic [1:0]               write_status,
    input  logic [1:0]               write_back_type,
    input  logic                     load_unsigned,
    input  logic [4:0]               destination_register_number,
    output logic                     out_valid,
    output logic [31:0]              alu_result,
    output logic [31:0]              store_data,
    output logic [1:0]               read_status_output,
    output logic [1:0]               write_status_output,
    output logic [1:0]               write_back_type_output,
    output logic                     load_unsigned_output,
    output logic [4:0]               destination_register_number_output,
    output logic                     redirect_valid,
    output logic [31:0]              redirect_pc,
    output logic [MISPRED_CNT_W-1:0] mispredict_count
);
    typedef enum logic {RUN, SQUASH} state_t;

    state_t                   state_reg, state_next;
    logic                     out_valid_reg;
    logic [31:0]              alu_result_reg, store_data_reg, redirect_pc_reg;
    logic [1:0]               read_status_reg, write_status_reg, write_back_type_reg;
    logic                     load_unsigned_reg;
    logic [4:0]               dest_reg;
    logic                     redirect_valid_reg;
    logic [MISPRED_CNT_W-1:0] mispredict_count_reg;

    logic [31:0] alu_value;
    logic        cond_true, branch_op, accept, issue, mispredict;
    logic [4:0]  shamt;

    assign shamt     = data_b[4:0];
    assign in_ready  = ~stall;
    assign accept    = in_valid & ~stall;
    assign issue     = accept && (state_reg == RUN);
    assign branch_op = (execute_instruction >= 5'd10) && (execute_instruction <= 5'd15);
    // Only flagged conditional branches consult the prediction.
    assign mispredict = issue && condition_branch && branch_op && (cond_true != taken);

    always_comb begin
        alu_value = 32'd0;
        cond_true = 1'b0;
        case (execute_instruction)
            5'd0:  alu_value = data_a + data_b;
            5'd1:  alu_value = data_a - data_b;
            5'd2:  alu_value = data_a << shamt;
            5'd3:  alu_value = {31'd0, $signed(data_a) < $signed(data_b)};
            5'd4:  alu_value = {31'd0, data_a < data_b};
            5'd5:  alu_value = data_a ^ data_b;
            5'd6:  alu_value = data_a >> shamt;
            5'd7:  alu_value = $unsigned($signed(data_a) >>> shamt);
            5'd8:  alu_value = data_a | data_b;
            5'd9:  alu_value = data_a & data_b;
            5'd10: cond_true = (data_a == data_b);
            5'd11: cond_true = (data_a != data_b);
            5'd12: cond_true = $signed(data_a) < $signed(data_b);
            5'd13: cond_true = $signed(data_a) >= $signed(data_b);
            5'd14: cond_true = data_a < data_b;
            5'd15: cond_true = data_a >= data_b;
            5'd16: alu_value = data_b;
            5'd17: alu_value = data_a + 32'd4;
            default: alu_value = 32'd0;
        endcase
        if (branch_op) alu_value = {31'd0, cond_true};
    end

    always_comb begin
        state_next = state_reg;
        if (accept) begin
            // The instruction following a mispredicted branch is dropped, then normal flow resumes.
            if (state_reg == SQUASH) state_next = RUN;
            else if (mispredict)     state_next = SQUASH;
            else                     state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg            <= RUN;
            out_valid_reg        <= 1'b0;
            alu_result_reg       <= 32'd0;
            store_data_reg       <= 32'd0;
            read_status_reg      <= 2'd0;
            write_status_reg     <= 2'd0;
            write_back_type_reg  <= 2'd0;
            load_unsigned_reg    <= 1'b0;
            dest_reg             <= 5'd0;
            redirect_valid_reg   <= 1'b0;
            redirect_pc_reg      <= 32'd0;
            mispredict_count_reg <= '0;
        end else begin
            state_reg          <= state_next;
            redirect_valid_reg <= mispredict;
            if (!stall) begin
                out_valid_reg <= issue;
                if (issue) begin
                    alu_result_reg      <= alu_value;
                    store_data_reg      <= rs2_value;
                    read_status_reg     <= read_status;
                    write_status_reg    <= write_status;
                    write_back_type_reg <= write_back_type;
                    load_unsigned_reg   <= load_unsigned;
                    dest_reg            <= destination_register_number;
                end
            end
            if (mispredict) begin
                redirect_pc_reg <= cond_true ? (pc + immediate_value) : (pc + 32'd4);
                if (mispredict_count_reg != '1)
                    mispredict_count_reg <= mispredict_count_reg + 1'b1;
            end
        end
    end

    assign out_valid                          = out_valid_reg;
    assign alu_result                         = alu_result_reg;
    assign store_data                         = store_data_reg;
    assign read_status_output                 = read_status_reg;
    assign write_status_output                = write_status_reg;
    assign write_back_type_output             = write_back_type_reg;
    assign load_unsigned_output               = load_unsigned_reg;
    assign destination_register_number_output = dest_reg;
    assign redirect_valid                     = redirect_valid_reg;
    assign redirect_pc                        = redirect_pc_reg;
    assign mispredict_count                   = mispredict_count_reg;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage; a second instance with a 4-bit counter
// shares all inputs so counter saturation is reachable in few cycles.
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, stall, condition_branch, taken, load_unsigned;
    logic [31:0] data_a, data_b, rs2_value, immediate_value, pc;
    logic [4:0]  execute_instruction, destination_register_number;
    logic [1:0]  read_status, write_status, write_back_type;

    logic        in_ready, out_valid, load_unsigned_output, redirect_valid;
    logic [31:0] alu_result, store_data, redirect_pc;
    logic [1:0]  read_status_output, write_status_output, write_back_type_output;
    logic [4:0]  destination_register_number_output;
    logic [15:0] mispredict_count;

    logic        s_in_ready, s_out_valid, s_load_unsigned_output, s_redirect_valid;
    logic [31:0] s_alu_result, s_store_data, s_redirect_pc;
    logic [1:0]  s_read_status_output, s_write_status_output, s_write_back_type_output;
    logic [4:0]  s_destination_register_number_output;
    logic [3:0]  s_mispredict_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .in_ready(in_ready),
        .data_a(data_a), .data_b(data_b), .rs2_value(rs2_value),
        .execute_instruction(execute_instruction), .condition_branch(condition_branch),
        .taken(taken), .immediate_value(immediate_value), .pc(pc),
        .read_status(read_status), .write_status(write_status), .write_back_type(write_back_type),
        .load_unsigned(load_unsigned), .destination_register_number(destination_register_number),
        .out_valid(out_valid), .alu_result(alu_result), .store_data(store_data),
        .read_status_output(read_status_output), .write_status_output(write_status_output),
        .write_back_type_output(write_back_type_output), .load_unsigned_output(load_unsigned_output),
        .destination_register_number_output(destination_register_number_output),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mispredict_count(mispredict_count)
    );

    execute_stage #(.MISPRED_CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .in_ready(s_in_ready),
        .data_a(data_a), .data_b(data_b), .rs2_value(rs2_value),
        .execute_instruction(execute_instruction), .condition_branch(condition_branch),
        .taken(taken), .immediate_value(immediate_value), .pc(pc),
        .read_status(read_status), .write_status(write_status), .write_back_type(write_back_type),
        .load_unsigned(load_unsigned), .destination_register_number(destination_register_number),
        .out_valid(s_out_valid), .alu_result(s_alu_result), .store_data(s_store_data),
        .read_status_output(s_read_status_output), .write_status_output(s_write_status_output),
        .write_back_type_output(s_write_back_type_output), .load_unsigned_output(s_load_unsigned_output),
        .destination_register_number_output(s_destination_register_number_output),
        .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc), .mispredict_count(s_mispredict_count)
    );

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t alu_vec [19] = '{
        '{5'd0,  32'd5,          32'hFFFFFFFE, 32'd3},
        '{5'd1,  32'd3,          32'd5,        32'hFFFFFFFE},
        '{5'd2,  32'd1,          32'h21,       32'd2},
        '{5'd3,  32'd1,          32'hFFFFFFFF, 32'd0},
        '{5'd4,  32'd1,          32'hFFFFFFFF, 32'd1},
        '{5'd5,  32'hF0F0F0F0,   32'hFF00FF00, 32'h0FF00FF0},
        '{5'd6,  32'h80000000,   32'd4,        32'h08000000},
        '{5'd7,  32'h80000000,   32'h24,       32'hF8000000},
        '{5'd8,  32'h0F000000,   32'h000000F0, 32'h0F0000F0},
        '{5'd9,  32'hF0F0F0F0,   32'hFF00FF00, 32'hF000F000},
        '{5'd10, 32'd9,          32'd9,        32'd1},
        '{5'd11, 32'd1,          32'd2,        32'd1},
        '{5'd12, 32'hFFFFFFFF,   32'd1,        32'd1},
        '{5'd13, 32'hFFFFFFFF,   32'd1,        32'd0},
        '{5'd14, 32'd1,          32'd2,        32'd1},
        '{5'd15, 32'd1,          32'hFFFFFFFF, 32'd0},
        '{5'd16, 32'h1234,       32'hABCD,     32'hABCD},
        '{5'd17, 32'h1000,       32'd7,        32'h1004},
        '{5'd20, 32'd7,          32'd7,        32'd0}
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid            = v;
        execute_instruction = op;
        data_a              = a;
        data_b              = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        condition_branch = 1'b0;
        taken = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; condition_branch = 1'b0; taken = 1'b0;
        rs2_value = 32'h55; immediate_value = 32'd0; pc = 32'd0;
        read_status = 2'd3; write_status = 2'd3; write_back_type = 2'd3;
        load_unsigned = 1'b1; destination_register_number = 5'd31;
        drive(1'b1, 5'd0, 32'd1, 32'd1);
        tick();
        checks++;
        if ({out_valid, alu_result, store_data, redirect_valid, redirect_pc, mispredict_count,
             read_status_output, write_status_output, write_back_type_output,
             load_unsigned_output, destination_register_number_output} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: out_valid=%b alu=%h store=%h rv=%b rpc=%h cnt=%h, required all zero",
                     out_valid, alu_result, store_data, redirect_valid, redirect_pc, mispredict_count);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL in_ready_nostall: got %b want 1", in_ready); end
        stall = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_stall: got %b want 0", in_ready); end
        stall = 1'b0;
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_alu();
        for (int i = 0; i < 19; i++) begin
            drive(1'b1, alu_vec[i].op, alu_vec[i].a, alu_vec[i].b);
            condition_branch = 1'b0;
            taken = i[0];
            tick();
            checks++;
            if (out_valid !== 1'b1 || alu_result !== alu_vec[i].exp || redirect_valid !== 1'b0) begin
                errors++;
                $display("FAIL alu_op%0d: valid=%b result=%h rv=%b, required valid=1 result=%h rv=0",
                         alu_vec[i].op, out_valid, alu_result, redirect_valid, alu_vec[i].exp);
            end
            $display("alu op=%0d a=%h b=%h -> %h", alu_vec[i].op, alu_vec[i].a, alu_vec[i].b, alu_result);
        end
    endtask

    task automatic test_passthrough();
        rs2_value = 32'hDEADBEEF; read_status = 2'd2; write_status = 2'd1;
        write_back_type = 2'd3; load_unsigned = 1'b1; destination_register_number = 5'd17;
        drive(1'b1, 5'd0, 32'd10, 32'd20);
        tick();
        checks++;
        if (store_data !== 32'hDEADBEEF || read_status_output !== 2'd2 || write_status_output !== 2'd1 ||
            write_back_type_output !== 2'd3 || load_unsigned_output !== 1'b1 ||
            destination_register_number_output !== 5'd17 || alu_result !== 32'd30) begin
            errors++;
            $display("FAIL passthrough: store=%h rs=%0d ws=%0d wb=%0d lu=%b rd=%0d alu=%h, required deadbeef 2 1 3 1 17 1e",
                     store_data, read_status_output, write_status_output, write_back_type_output,
                     load_unsigned_output, destination_register_number_output, alu_result);
        end
        drive(1'b0, 5'd1, 32'd0, 32'd0);
        rs2_value = 32'h0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || alu_result !== 32'd30 || store_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bubble_hold: valid=%b alu=%h store=%h, required 0 1e deadbeef", out_valid, alu_result, store_data);
        end
        $display("test_passthrough done");
    endtask

    task automatic test_beq_mispredict();
        do_reset();
        drive(1'b1, 5'd10, 32'd7, 32'd7);
        condition_branch = 1'b1; taken = 1'b0; pc = 32'h100; immediate_value = 32'h20;
        tick();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120 || mispredict_count !== 16'd1 ||
            out_valid !== 1'b1 || alu_result !== 32'd1) begin
            errors++;
            $display("FAIL beq_redirect: rv=%b rpc=%h cnt=%0d valid=%b alu=%h, required 1 120 1 1 1",
                     redirect_valid, redirect_pc, mispredict_count, out_valid, alu_result);
        end
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        condition_branch = 1'b0;
        tick();
        checks++;
        if (redirect_valid !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL beq_pulse_end: rv=%b valid=%b, required 0 0", redirect_valid, out_valid);
        end
        drive(1'b1, 5'd0, 32'd1, 32'd1);
        tick();
        checks++;
        if (out_valid !== 1'b0 || alu_result !== 32'd1 || mispredict_count !== 16'd1) begin
            errors++;
            $display("FAIL beq_squash: valid=%b alu=%h cnt=%0d, required 0 1 1", out_valid, alu_result, mispredict_count);
        end
        drive(1'b1, 5'd0, 32'd2, 32'd3);
        tick();
        checks++;
        if (out_valid !== 1'b1 || alu_result !== 32'd5) begin
            errors++;
            $display("FAIL beq_resume: valid=%b alu=%h, required 1 5", out_valid, alu_result);
        end
        drive(1'b1, 5'd14, 32'd1, 32'd2);
        condition_branch = 1'b1; taken = 1'b1;
        tick();
        checks++;
        if (redirect_valid !== 1'b0 || out_valid !== 1'b1 || alu_result !== 32'd1 || mispredict_count !== 16'd1) begin
            errors++;
            $display("FAIL bltu_correct: rv=%b valid=%b alu=%h cnt=%0d, required 0 1 1 1",
                     redirect_valid, out_valid, alu_result, mispredict_count);
        end
        condition_branch = 1'b0;
        $display("test_beq_mispredict done");
    endtask

    task automatic test_bne_stall();
        do_reset();
        rs2_value = 32'hCAFE0001;
        drive(1'b1, 5'd11, 32'd4, 32'd4);
        condition_branch = 1'b1; taken = 1'b1; pc = 32'h200; immediate_value = 32'h40;
        tick();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h204 || mispredict_count !== 16'd1 || alu_result !== 32'd0) begin
            errors++;
            $display("FAIL bne_redirect: rv=%b rpc=%h cnt=%0d alu=%h, required 1 204 1 0",
                     redirect_valid, redirect_pc, mispredict_count, alu_result);
        end
        stall = 1'b1;
        rs2_value = 32'h0;
        drive(1'b1, 5'd0, 32'd9, 32'd9);
        condition_branch = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (redirect_valid !== 1'b0 || out_valid !== 1'b1 || store_data !== 32'hCAFE0001 ||
                redirect_pc !== 32'h204 || mispredict_count !== 16'd1) begin
                errors++;
                $display("FAIL bne_stall_hold%0d: rv=%b valid=%b store=%h rpc=%h cnt=%0d, required 0 1 cafe0001 204 1",
                         i, redirect_valid, out_valid, store_data, redirect_pc, mispredict_count);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || store_data !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL bne_squash_after_stall: valid=%b store=%h, required 0 cafe0001", out_valid, store_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || alu_result !== 32'd18) begin
            errors++;
            $display("FAIL bne_resume: valid=%b alu=%h, required 1 12", out_valid, alu_result);
        end
        $display("test_bne_stall done");
    endtask

    task automatic test_saturation();
        do_reset();
        pc = 32'h300; immediate_value = 32'h8;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 5'd10, 32'd1, 32'd1);
            condition_branch = 1'b1; taken = 1'b0;
            tick();
            checks++;
            if (s_redirect_valid !== 1'b1 || s_mispredict_count !== ((i < 15) ? 4'(i + 1) : 4'hF) ||
                mispredict_count !== 16'(i + 1)) begin
                errors++;
                $display("FAIL sat_count%0d: small_rv=%b small=%h wide=%0d, required 1 %h %0d",
                         i, s_redirect_valid, s_mispredict_count, mispredict_count,
                         (i < 15) ? 4'(i + 1) : 4'hF, i + 1);
            end
            drive(1'b1, 5'd0, 32'd0, 32'd0);
            condition_branch = 1'b0;
            tick();
        end
        $display("test_saturation small=%h wide=%0d", s_mispredict_count, mispredict_count);
    endtask

    task automatic test_reset_squash();
        do_reset();
        drive(1'b1, 5'd10, 32'd3, 32'd3);
        condition_branch = 1'b1; taken = 1'b0; pc = 32'h400; immediate_value = 32'h10;
        tick();
        rst_n = 1'b0;
        drive(1'b1, 5'd10, 32'd3, 32'd3);
        tick();
        checks++;
        if ({out_valid, alu_result, redirect_valid, redirect_pc, mispredict_count, store_data} !== '0) begin
            errors++;
            $display("FAIL reset_in_squash: valid=%b alu=%h rv=%b rpc=%h cnt=%0d, required all zero",
                     out_valid, alu_result, redirect_valid, redirect_pc, mispredict_count);
        end
        rst_n = 1'b1;
        drive(1'b1, 5'd0, 32'd2, 32'd3);
        condition_branch = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || alu_result !== 32'd5 || redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_not_squashed: valid=%b alu=%h rv=%b, required 1 5 0", out_valid, alu_result, redirect_valid);
        end
        $display("test_reset_squash done");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_passthrough();
        test_beq_mispredict();
        test_bne_stall();
        test_saturation();
        test_reset_squash();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
